// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension arbiter: default widths,
// FSM state encoding, requester index type and the round-robin pick rule.
package imm_ext_pkg;

    localparam int IMM_W_DEF  = 16;
    localparam int DATA_W_DEF = 32;

    // Output register occupancy.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } fsm_state_e;

    // Index of one of the two requesters.
    typedef logic req_idx_t;

    // Round-robin choice between two requesters: a lone valid requester wins;
    // under contention the one that was not served last wins.
    function automatic req_idx_t rr_pick(input logic v0, input logic v1,
                                         input req_idx_t last_src);
        if (v0 && v1) begin
            return ~last_src;
        end
        if (v1) begin
            return 1'b1;
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/imm_ext_unit.sv
// Combinational immediate extender: copies imm into the low bits and fills
// the upper bits with the sign bit, or with zeros when zext is set.
module imm_ext_unit
    import imm_ext_pkg::*;
#(
    parameter int IMM_W  = IMM_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [IMM_W-1:0]  imm,
    input  logic              zext,
    output logic [DATA_W-1:0] ext
);

    logic fill_bit;

    // Upper-bit fill value chosen by the extension mode.
    assign fill_bit = zext ? 1'b0 : imm[IMM_W-1];
    assign ext      = {{(DATA_W-IMM_W){fill_bit}}, imm};

endmodule

// File: rtl/imm_ext_arbiter.sv
// Two-requester arbiter sharing one immediate extension unit, with a
// one-entry registered output.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. Requester readies are combinational from the valids, the
// round-robin pointer, the FSM state and out_ready; a requester must not make
// valid depend on ready. out_valid/out_data/out_src hold while out_valid is
// high and out_ready is low.
//
// Optional feature: define IMM_ZEXT_EN to add req0_zext/req1_zext, which
// select zero-extension for the accepted request. Without it every immediate
// is sign-extended.
//
// state_dbg exposes the FSM state for observation.
module imm_ext_arbiter
    import imm_ext_pkg::*;
#(
    parameter int IMM_W  = IMM_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [IMM_W-1:0]  req0_imm,
`ifdef IMM_ZEXT_EN
    input  logic              req0_zext,
`endif
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [IMM_W-1:0]  req1_imm,
`ifdef IMM_ZEXT_EN
    input  logic              req1_zext,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output req_idx_t          out_src,
    output fsm_state_e        state_dbg
);

    fsm_state_e        state, state_next;
    req_idx_t          last_src;
    req_idx_t          grant_src;
    logic              any_valid;
    logic              can_accept;
    logic              accept;
    logic [IMM_W-1:0]  sel_imm;
    logic              sel_zext;
    logic [DATA_W-1:0] ext_value;

    // Grant depends only on the valids and the round-robin pointer.
    always_comb begin
        any_valid  = req0_valid | req1_valid;
        grant_src  = rr_pick(req0_valid, req1_valid, last_src);
        can_accept = rst_n & ((state == ST_EMPTY) | out_ready);
        req0_ready = req0_valid & (grant_src == 1'b0) & can_accept;
        req1_ready = req1_valid & (grant_src == 1'b1) & can_accept;
        accept     = any_valid & can_accept;
    end

    // Steer the granted requester's immediate into the shared extender.
    always_comb begin
        sel_imm = (grant_src == 1'b1) ? req1_imm : req0_imm;
`ifdef IMM_ZEXT_EN
        sel_zext = (grant_src == 1'b1) ? req1_zext : req0_zext;
`else
        sel_zext = 1'b0;
`endif
    end

    imm_ext_unit #(
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W)
    ) u_ext (
        .imm  (sel_imm),
        .zext (sel_zext),
        .ext  (ext_value)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: fill on accept, drain on out_ready, refill in the
    // same cycle when a new request is accepted alongside the drain.
    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_ready && !accept) begin
                    state_next = ST_EMPTY;
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
    end

    // Output register and round-robin pointer; both update only on accept.
    // last_src resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data <= '0;
            out_src  <= 1'b0;
            last_src <= 1'b1;
        end else if (accept) begin
            out_data <= ext_value;
            out_src  <= grant_src;
            last_src <= grant_src;
        end
    end

    assign out_valid = (state == ST_FULL);
    assign state_dbg = state;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Self-checking bench for imm_ext_arbiter: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_imm_ext_arbiter;
    import imm_ext_pkg::*;

    localparam int IMM_W  = 16;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst_n;
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [IMM_W-1:0]  req0_imm, req1_imm;
    logic              req0_zext, req1_zext;
    logic              out_valid, out_ready;
    logic [DATA_W-1:0] out_data;
    req_idx_t          out_src;
    fsm_state_e        state_dbg;

    imm_ext_arbiter #(
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_imm   (req0_imm),
`ifdef IMM_ZEXT_EN
        .req0_zext  (req0_zext),
`endif
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_imm   (req1_imm),
`ifdef IMM_ZEXT_EN
        .req1_zext  (req1_zext),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_src    (out_src),
        .state_dbg  (state_dbg)
    );

    // Clock and checking counters.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: pending results (src in MSB) and round-robin memory.
    logic [DATA_W:0] exp_q[$];
    int              model_last = 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Extension from arithmetic: a negative immediate adds 2^DATA_W - 2^IMM_W.
    function automatic logic [DATA_W-1:0] ref_ext(input logic [IMM_W-1:0] imm, input logic z);
        longint unsigned v;
        v = longint'(imm);
        if (!z && (v >= (64'd1 << (IMM_W - 1)))) begin
            v = v + ((64'd1 << DATA_W) - (64'd1 << IMM_W));
        end
        return v[DATA_W-1:0];
    endfunction

    // One clock of traffic: drive, check at negedge, advance model at posedge.
    task automatic step(input logic v0, input logic [IMM_W-1:0] i0, input logic z0,
                        input logic v1, input logic [IMM_W-1:0] i1, input logic z1,
                        input logic ordy);
        logic            has, space, acc;
        int              pick;
        logic [DATA_W:0] front;
        logic            zsel;
        req0_valid = v0; req0_imm = i0; req0_zext = z0;
        req1_valid = v1; req1_imm = i1; req1_zext = z1;
        out_ready  = ordy;
        @(negedge clk);
        has   = (exp_q.size() != 0);
        space = !has || ordy;
        if (v0 && v1) pick = 1 - model_last;
        else if (v1)  pick = 1;
        else          pick = 0;
        acc = (v0 || v1) && space;
        chk("req0_ready", 64'(req0_ready), 64'(acc && pick == 0));
        chk("req1_ready", 64'(req1_ready), 64'(acc && pick == 1));
        chk("out_valid", 64'(out_valid), 64'(has));
        if (has) begin
            front = exp_q[0];
            chk("out_data", 64'(out_data), 64'(front[DATA_W-1:0]));
            chk("out_src", 64'(out_src), 64'(front[DATA_W]));
        end
        @(posedge clk);
        if (has && ordy) void'(exp_q.pop_front());
        if (acc) begin
`ifdef IMM_ZEXT_EN
            zsel = (pick == 1) ? z1 : z0;
`else
            zsel = 1'b0;
`endif
            exp_q.push_back({1'(pick), ref_ext((pick == 1) ? i1 : i0, zsel)});
            model_last = pick;
        end
        #1;
    endtask

    // Hold reset for n cycles with current requests; readies must stay low.
    task automatic apply_reset(input int n);
        rst_n = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("rst_req0_ready", 64'(req0_ready), 64'd0);
            chk("rst_req1_ready", 64'(req1_ready), 64'd0);
            @(posedge clk);
            exp_q.delete();
            model_last = 1;
            #1;
        end
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_src", 64'(out_src), 64'd0);
        rst_n = 1'b1;
    endtask

    // Stimulus.
    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_imm = '0; req1_imm = '0;
        req0_zext = 1'b0; req1_zext = 1'b0;
        out_ready = 1'b1;
        #1;
        apply_reset(2);

        // Single sign-extended request.
        step(1, 16'h8001, 0, 0, 16'h0000, 0, 1);
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_data", 64'(out_data), 64'hFFFF8001);
        chk("t1_src", 64'(out_src), 64'd0);
        step(0, 16'h0000, 0, 0, 16'h0000, 0, 1);

        // Contention from reset: requester 0 first, then requester 1.
        apply_reset(1);
        step(1, 16'h0005, 0, 1, 16'hFFFE, 0, 1);
        chk("t2_data0", 64'(out_data), 64'h00000005);
        chk("t2_src0", 64'(out_src), 64'd0);
        step(1, 16'h0005, 0, 1, 16'hFFFE, 0, 1);
        chk("t2_data1", 64'(out_data), 64'hFFFFFFFE);
        chk("t2_src1", 64'(out_src), 64'd1);
        step(0, 16'h0000, 0, 0, 16'h0000, 0, 1);

        // Stalled output with both requesters waiting, then drain and refill.
        step(1, 16'h1234, 0, 0, 16'h0000, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 16'h7777, 0, 1, 16'h9999, 0, 0);
            chk("t3_hold_data", 64'(out_data), 64'h00001234);
        end
        step(1, 16'h7777, 0, 1, 16'h9999, 0, 1);
        chk("t3_refill_data", 64'(out_data), 64'hFFFF9999);
        step(0, 16'h0000, 0, 0, 16'h0000, 0, 1);

`ifdef IMM_ZEXT_EN
        step(0, 16'h0000, 0, 1, 16'h8000, 1, 1);
        chk("t4_zext", 64'(out_data), 64'h00008000);
        step(0, 16'h0000, 0, 1, 16'h8000, 0, 1);
        chk("t4_sext", 64'(out_data), 64'hFFFF8000);
        step(0, 16'h0000, 0, 0, 16'h0000, 0, 1);
`endif

        // Reset while FULL with requester 0 pending.
        step(0, 16'h0000, 0, 1, 16'h0042, 0, 0);
        step(1, 16'h0011, 0, 0, 16'h0000, 0, 0);
        apply_reset(1);
        step(1, 16'h0021, 0, 1, 16'h0022, 0, 1);
        chk("t5_src", 64'(out_src), 64'd0);
        chk("t5_data", 64'(out_data), 64'h00000021);

        // Random traffic with occasional reset.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                apply_reset(1);
            end else begin
                step(1'($urandom_range(0, 1)), IMM_W'($urandom_range(0, 65535)),
                     1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), IMM_W'($urandom_range(0, 65535)),
                     1'($urandom_range(0, 1)),
                     ($urandom_range(0, 9) < 7));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imm_ext_arbiter.md
IMM_EXT_ARBITER -- requirements
Module: imm_ext_arbiter

Interface
REQ-001 SHALL have parameter IMM_W, default 16, immediate field width.
REQ-002 SHALL have parameter DATA_W, default 32, extended result width; DATA_W > IMM_W.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports req0_valid/req1_valid  input  1  requester has an immediate pending.
REQ-006 SHALL have ports req0_ready/req1_ready  output  1  requester's immediate accepted this cycle.
REQ-007 SHALL have ports req0_imm/req1_imm  input  IMM_W  raw immediate.
REQ-008 SHALL have ports req0_zext/req1_zext  input  1  zero-extend select; present only with IMM_ZEXT_EN.
REQ-009 SHALL have port out_valid  output  1  out_data holds a result.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port out_data  output  DATA_W  extended immediate.
REQ-012 SHALL have port out_src  output  1  index of the requester that produced out_data.

Function
REQ-013 SHALL share one extension unit between two requesters; transfer occurs when valid and ready are both high.
REQ-014 SHALL run a two-state FSM: EMPTY (output register empty) and FULL (output register holds a result).
REQ-015 SHALL drive reqN_ready = grantN & (state==EMPTY | out_ready); never both readies high.
REQ-016 SHALL grant the only valid requester when one is valid; with both valid, SHALL grant the one not served last (round-robin pointer last_src).
REQ-017 SHALL update last_src to the accepted requester index on every accept, and only on accept.
REQ-018 SHALL register the extended result, so latency is exactly 1 cycle from accept to out_valid high.
REQ-019 SHALL sign-extend: out_data[DATA_W-1:IMM_W] = copies of imm[IMM_W-1]; out_data[IMM_W-1:0] = imm.
REQ-020 SHALL hold out_data, out_src and out_valid stable while out_valid & !out_ready.
REQ-021 Transitions: EMPTY->FULL on accept; FULL->EMPTY on out_ready with no accept; FULL->FULL on out_ready with accept (back-to-back, one result per cycle); otherwise hold.
REQ-022 SHALL let grant depend only on valids and last_src, never on imm contents.
REQ-023 SHALL sustain full throughput: with both requesters valid and out_ready high, accepts alternate 0,1,0,1 every cycle.

Reset
REQ-024 SHALL, while rst_n low at a clock edge: state=EMPTY, out_valid=0, out_data=0, out_src=0, last_src=1 (requester 0 wins first contention).
REQ-025 SHALL drop an in-flight result when reset is asserted mid-operation; no stale out_valid after release.
REQ-026 SHALL hold req0_ready/req1_ready low while rst_n is low.

Configuration
REQ-027 SHALL, with IMM_ZEXT_EN defined, provide reqN_zext and fill upper bits with 0 when the accepted request's zext=1, sign bit otherwise.
REQ-028 SHALL, without IMM_ZEXT_EN, omit reqN_zext ports and always sign-extend.

Structure
REQ-029 SHALL take IMM_W/DATA_W defaults, FSM state encoding (EMPTY=0, FULL=1) and requester-index type from the shared package imm_ext_pkg.
REQ-030 SHALL place the combinational extension in sub-module imm_ext_unit (imm, zext -> extended value); arbiter and FSM stay in imm_ext_arbiter.

Verification
REQ-031 Reset then req0_valid=1, imm=16'h8001, out_ready=1 -> next cycle out_valid=1, out_data=32'hFFFF8001, out_src=0.
REQ-032 Both valid from reset, imm0=16'h0005, imm1=16'hFFFE, out_ready=1 -> results 32'h00000005 (src 0) then 32'hFFFFFFFE (src 1) on consecutive cycles.
REQ-033 Result pending, out_ready=0 for 3 cycles, both valid -> both readies 0, out_data stable; out_ready=1 -> drained and next accept in same cycle.
REQ-034 IMM_ZEXT_EN build, req1_imm=16'h8000, zext=1 -> 32'h00008000; zext=0 -> 32'hFFFF8000.
REQ-035 rst_n low one cycle while FULL and req0 valid -> out_valid=0, next contention granted to requester 0.
